// File: rtl/alu_op_sequencer.sv
// Single-issue sequencer: owns a small register file, feeds operands to an external ALU
// and writes the ALU result back one cycle after accepting each instruction.
module alu_op_sequencer #(
   parameter int DATA_W = 4,
   parameter int IDX_W  = 2,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   input  logic [3*IDX_W+2:0]   instr,
   output logic                 instr_ready,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [DATA_W-1:0]    rd_data,
   output logic [DATA_W-1:0]    alu_rs,
   output logic [DATA_W-1:0]    alu_rt,
   output logic [2:0]           alu_sel,
   input  logic [DATA_W-1:0]    alu_rd,
   output logic                 done,
   output logic [IDX_W-1:0]     done_idx,
   output logic [DATA_W-1:0]    done_data,
   output logic                 cmp_flag,
   output logic [CNT_W-1:0]     instr_count
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t               state_q, state_d;
   logic                 accept;
   logic [DATA_W-1:0]    regs [2**IDX_W];
   logic [IDX_W-1:0]     dst_p1;

   logic [2:0]           op_f;
   logic [IDX_W-1:0]     rd_f, rs_f, rt_f;

   // Compare ops (6, 7) report their verdict in bit 0 of the ALU result.
   function automatic logic is_cmp(input logic [2:0] sel);
      return sel[2] & sel[1];
   endfunction

   assign op_f = instr[3*IDX_W+2 -: 3];
   assign rd_f = instr[3*IDX_W-1 -: IDX_W];
   assign rs_f = instr[2*IDX_W-1 -: IDX_W];
   assign rt_f = instr[IDX_W-1:0];

   assign instr_ready = (state_q == IDLE) && !wr_en && !rst;
   assign rd_data     = regs[rd_idx];

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!wr_en && instr_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**IDX_W; i++) regs[i] <= '0;
         alu_rs      <= '0;
         alu_rt      <= '0;
         alu_sel     <= '0;
         dst_p1      <= '0;
         done        <= 1'b0;
         done_idx    <= '0;
         done_data   <= '0;
         cmp_flag    <= 1'b0;
         instr_count <= '0;
      end else begin
         done <= 1'b0;
         // Issue stage: host write wins over instruction accept
         if (state_q == IDLE) begin
            if (wr_en) begin
               regs[wr_idx] <= wr_data;
            end else if (accept) begin
               alu_sel <= op_f;
               alu_rs  <= regs[rs_f];
               alu_rt  <= regs[rt_f];
               dst_p1  <= rd_f;
            end
         end else begin
            // Writeback stage: host writes arriving now are dropped
            regs[dst_p1] <= alu_rd;
            done         <= 1'b1;
            done_idx     <= dst_p1;
            done_data    <= alu_rd;
            instr_count  <= instr_count + 1'b1;
            if (is_cmp(alu_sel)) cmp_flag <= alu_rd[0];
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU model on the alu_* ports, shadow register
// file, and a scoreboard of expected writebacks checked whenever done pulses.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic [8:0] instr;
   logic       instr_ready;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [3:0] wr_data;
   logic [1:0] rd_idx;
   logic [3:0] rd_data;
   logic [3:0] alu_rs, alu_rt, alu_rd;
   logic [2:0] alu_sel;
   logic       done;
   logic [1:0] done_idx;
   logic [3:0] done_data;
   logic       cmp_flag;
   logic [7:0] instr_count;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] idx;
      logic [3:0] data;
      logic       cmp;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] shadow [4];
   logic [7:0] exp_cnt;
   logic       exp_cmp;

   int  cyc = 0;
   int  last_done_cyc = 0;
   int  b2b_pulses = 0;
   bit  b2b_mode = 0;

   alu_op_sequencer #(.DATA_W(4), .IDX_W(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_idx(rd_idx), .rd_data(rd_data), .alu_rs(alu_rs), .alu_rt(alu_rt),
      .alu_sel(alu_sel), .alu_rd(alu_rd), .done(done), .done_idx(done_idx),
      .done_data(done_data), .cmp_flag(cmp_flag), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // External ALU stand-in
   function automatic logic [3:0] alu_fn(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
      case (sel)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return {a[2:0], a[3]};
         3'd5: return {b[3], b[3:1]};
         3'd6: return {3'b101, (a > b)};
         default: return {3'b111, (a == b)};
      endcase
   endfunction

   assign alu_rd = alu_fn(alu_sel, alu_rs, alu_rt);

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer
   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected: done=1 with no pending instruction (done_idx=%0d done_data=%0d)", done_idx, done_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({done_idx, done_data, cmp_flag, instr_count} !== {e.idx, e.data, e.cmp, e.cnt}) begin
               failures++;
               $display("FAIL writeback: got idx=%0d data=%0d cmp=%0d cnt=%0d, want idx=%0d data=%0d cmp=%0d cnt=%0d",
                        done_idx, done_data, cmp_flag, instr_count, e.idx, e.data, e.cmp, e.cnt);
            end
         end
         if (b2b_mode) begin
            if (b2b_pulses > 0) begin
               checks++;
               if (cyc - last_done_cyc !== 2) begin
                  failures++;
                  $display("FAIL done_spacing: got %0d cycles, want 2", cyc - last_done_cyc);
               end
            end
            b2b_pulses++;
         end
         last_done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!instr_ready && t < 20) begin tick(); t++; end
      if (!instr_ready) begin
         checks++; failures++;
         $display("FAIL ready_timeout: instr_ready=%0d, want 1", instr_ready);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 20) begin tick(); t++; end
      tick();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: pending=%0d, want 0", sb.size());
      end
   endtask

   task automatic host_write(input logic [1:0] idx, input logic [3:0] val);
      wait_ready();
      wr_en = 1; wr_idx = idx; wr_data = val;
      tick();
      wr_en = 0;
      shadow[idx] = val;
   endtask

   task automatic check_reg(input logic [1:0] idx, input string name);
      rd_idx = idx; #1;
      checks++;
      if (rd_data !== shadow[idx]) begin
         failures++;
         $display("FAIL %s: rd_data[r%0d]=%0d, want %0d", name, idx, rd_data, shadow[idx]);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] rt, input bit completes);
      logic [3:0] a, b, r;
      exp_t e;
      wait_ready();
      instr = {op, rd, rs, rt}; instr_valid = 1;
      a = shadow[rs]; b = shadow[rt]; r = alu_fn(op, a, b);
      if (completes) begin
         shadow[rd] = r;
         exp_cnt = exp_cnt + 1;
         if (op >= 3'd6) exp_cmp = r[0];
         e.idx = rd; e.data = r; e.cmp = exp_cmp; e.cnt = exp_cnt;
         sb.push_back(e);
      end
      tick();
      instr_valid = 0;
      checks++;
      if ({alu_sel, alu_rs, alu_rt} !== {op, a, b}) begin
         failures++;
         $display("FAIL operands: got sel=%0d rs=%0d rt=%0d, want sel=%0d rs=%0d rt=%0d",
                  alu_sel, alu_rs, alu_rt, op, a, b);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) shadow[i] = '0;
      exp_cnt = 0; exp_cmp = 0;
   endtask

   task automatic test_reset();
      rst = 1; instr_valid = 0; instr = '0; wr_en = 0; wr_idx = 0; wr_data = 0; rd_idx = 0;
      model_reset();
      tick(); tick();
      rst = 0; #1;
      checks++;
      if ({done, done_idx, done_data, cmp_flag, instr_count, alu_sel, alu_rs, alu_rt, instr_ready} !== {1'b0, 2'd0, 4'd0, 1'b0, 8'd0, 3'd0, 4'd0, 4'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state: done=%0d idx=%0d data=%0d cmp=%0d cnt=%0d sel=%0d rs=%0d rt=%0d ready=%0d, want all 0 and ready=1",
                  done, done_idx, done_data, cmp_flag, instr_count, alu_sel, alu_rs, alu_rt, instr_ready);
      end
      for (int i = 0; i < 4; i++) check_reg(i[1:0], "reset_regfile");
   endtask

   task automatic test_arith();
      host_write(2'd1, 4'd3);
      host_write(2'd2, 4'd5);
      issue(3'd0, 2'd0, 2'd1, 2'd2, 1);
      drain();
      check_reg(2'd0, "add_result");
      issue(3'd1, 2'd3, 2'd1, 2'd2, 1);
      issue(3'd6, 2'd0, 2'd2, 2'd1, 1);
      issue(3'd7, 2'd0, 2'd1, 2'd2, 1);
      issue(3'd2, 2'd1, 2'd3, 2'd2, 1);
      drain();
      check_reg(2'd3, "sub_result");
      check_reg(2'd0, "eq_result");
      check_reg(2'd1, "and_result");
   endtask

   task automatic test_shift_rotate();
      host_write(2'd1, 4'b1001);
      issue(3'd4, 2'd1, 2'd1, 2'd0, 1);
      host_write(2'd2, 4'b1000);
      issue(3'd5, 2'd3, 2'd0, 2'd2, 1);
      drain();
      check_reg(2'd1, "rotate_in_place");
      check_reg(2'd3, "asr_result");
   endtask

   task automatic test_write_priority();
      logic [3:0] a;
      exp_t e;
      wait_ready();
      wr_en = 1; wr_idx = 2'd2; wr_data = 4'd6;
      instr = {3'd0, 2'd3, 2'd1, 2'd2}; instr_valid = 1;
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin
         failures++;
         $display("FAIL write_priority_ready: instr_ready=%0d, want 0", instr_ready);
      end
      tick();
      wr_en = 0;
      shadow[2] = 4'd6;
      a = shadow[1];
      shadow[3] = a + 4'd6;
      exp_cnt = exp_cnt + 1;
      e.idx = 2'd3; e.data = shadow[3]; e.cmp = exp_cmp; e.cnt = exp_cnt;
      sb.push_back(e);
      tick();
      instr_valid = 0;
      checks++;
      if ({alu_sel, alu_rs, alu_rt} !== {3'd0, a, 4'd6}) begin
         failures++;
         $display("FAIL write_then_accept: got sel=%0d rs=%0d rt=%0d, want sel=0 rs=%0d rt=6",
                  alu_sel, alu_rs, alu_rt, a);
      end
      drain();
      check_reg(2'd2, "host_write_applied");
   endtask

   task automatic test_reset_abort();
      host_write(2'd0, 4'd7);
      issue(3'd0, 2'd0, 2'd1, 2'd2, 0);
      rst = 1;
      tick();
      rst = 0;
      model_reset();
      #1;
      checks++;
      if ({done, instr_count, instr_ready} !== {1'b0, 8'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_abort: done=%0d cnt=%0d ready=%0d, want done=0 cnt=0 ready=1",
                  done, instr_count, instr_ready);
      end
      check_reg(2'd0, "reset_abort_r0");
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort_late_done: done=%0d, want 0", done);
      end
   endtask

   task automatic test_back_to_back();
      host_write(2'd1, 4'b0101);
      host_write(2'd2, 4'b0010);
      b2b_mode = 1;
      b2b_pulses = 0;
      for (int i = 0; i < 256; i++)
         issue(3'd3, i[1:0], i[2:1], i[3:2], 1);
      drain();
      b2b_mode = 0;
      checks++;
      if (b2b_pulses !== 256) begin
         failures++;
         $display("FAIL b2b_pulse_count: got %0d, want 256", b2b_pulses);
      end
      checks++;
      if (instr_count !== 8'd0) begin
         failures++;
         $display("FAIL count_wrap: instr_count=%0d, want 0", instr_count);
      end
      for (int i = 0; i < 4; i++) check_reg(i[1:0], "b2b_regfile");
   endtask

   initial begin
      test_reset();
      test_arith();
      test_shift_rotate();
      test_write_priority();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
